// File: rtl/hazard_unit.sv
// Pipeline hazard detector: load-use interlock, multi-cycle mul/div EX occupancy,
// EX-flush priority over all stalls, and a saturating stall-cycle counter.
module hazard_unit #(
  parameter int MULDIV_LAT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_rd_we,
  input  logic        id_is_load,
  input  logic        id_is_muldiv,
  input  logic        flush_ex,
  output logic        stall_decode,
  output logic        flush_decode,
  output logic [15:0] stall_cnt,
  output logic        dbg_busy,
  output logic [3:0]  dbg_cnt,
  output logic        dbg_ex_valid
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MULDIV_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ex_valid_q, ex_valid_d;
  logic [4:0]  ex_rd_q, ex_rd_d;
  logic        ex_we_q, ex_we_d;
  logic        ex_is_load_q, ex_is_load_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic rs1_hit, rs2_hit, load_use, issue;

  // ex_rd_q != 0 already excludes any source reading x0.
  always_comb begin
    rs1_hit      = id_uses_rs1 && (id_rs1 == ex_rd_q);
    rs2_hit      = id_uses_rs2 && (id_rs2 == ex_rd_q);
    load_use     = ex_valid_q && ex_is_load_q && ex_we_q && (ex_rd_q != 5'd0) &&
                   (rs1_hit || rs2_hit);
    stall_decode = id_valid && !flush_ex && (load_use || (state_q == ST_BUSY));
    flush_decode = flush_ex;
    issue        = id_valid && !stall_decode && !flush_ex;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ex_valid_d   = 1'b0;
    ex_rd_d      = ex_rd_q;
    ex_we_d      = ex_we_q;
    ex_is_load_d = ex_is_load_q;
    stall_cnt_d  = stall_cnt_q;

    if (flush_ex) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue && id_is_muldiv) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
        ST_BUSY: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end

    // Without an issue the EX stage receives a bubble; stale fields are harmless.
    if (!flush_ex && issue) begin
      ex_valid_d   = 1'b1;
      ex_rd_d      = id_rd;
      ex_we_d      = id_rd_we;
      ex_is_load_d = id_is_load;
    end

    if (stall_decode && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      ex_valid_q   <= 1'b0;
      ex_rd_q      <= 5'd0;
      ex_we_q      <= 1'b0;
      ex_is_load_q <= 1'b0;
      stall_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ex_valid_q   <= ex_valid_d;
      ex_rd_q      <= ex_rd_d;
      ex_we_q      <= ex_we_d;
      ex_is_load_q <= ex_is_load_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign dbg_busy     = (state_q == ST_BUSY);
  assign dbg_cnt      = cnt_q;
  assign dbg_ex_valid = ex_valid_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: vector table, directed multi-cycle sequences, a randomized
// run against an issue-history model, and a counter-saturation run on a second instance.
module tb_hazard_unit;

  localparam int LAT     = 4;
  localparam int SAT_LAT = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        id_valid, id_uses_rs1, id_uses_rs2, id_rd_we, id_is_load, id_is_muldiv, flush_ex;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        stall_decode, flush_decode, dbg_busy, dbg_ex_valid;
  logic [15:0] stall_cnt;
  logic [3:0]  dbg_cnt;

  logic        s_reset_n, s_id_valid, s_id_is_muldiv;
  logic        s_stall_decode, s_flush_decode, s_dbg_busy, s_dbg_ex_valid;
  logic [15:0] s_stall_cnt;
  logic [3:0]  s_dbg_cnt;

  hazard_unit #(.MULDIV_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load), .id_is_muldiv(id_is_muldiv),
    .flush_ex(flush_ex), .stall_decode(stall_decode), .flush_decode(flush_decode),
    .stall_cnt(stall_cnt), .dbg_busy(dbg_busy), .dbg_cnt(dbg_cnt), .dbg_ex_valid(dbg_ex_valid)
  );

  hazard_unit #(.MULDIV_LAT(SAT_LAT)) dut_sat (
    .clk(clk), .reset_n(s_reset_n), .id_valid(s_id_valid),
    .id_rs1(5'd0), .id_rs2(5'd0), .id_uses_rs1(1'b0), .id_uses_rs2(1'b0),
    .id_rd(5'd0), .id_rd_we(1'b0), .id_is_load(1'b0), .id_is_muldiv(s_id_is_muldiv),
    .flush_ex(1'b0), .stall_decode(s_stall_decode), .flush_decode(s_flush_decode),
    .stall_cnt(s_stall_cnt), .dbg_busy(s_dbg_busy), .dbg_cnt(s_dbg_cnt),
    .dbg_ex_valid(s_dbg_ex_valid)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic md, input logic fl);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_rd = rd; id_rd_we = we; id_is_load = ld; id_is_muldiv = md; flush_ex = fl;
  endtask

  task automatic idle_in;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Inputs change at posedge+1, outputs are sampled at posedge+2.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    idle_in();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    step();
    exp_cnt = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0] a_rd; logic a_we; logic a_ld;
    logic [4:0] b_rs1; logic [4:0] b_rs2; logic b_u1; logic b_u2;
    logic exp_stall;
  } vec_t;
  vec_t vecs[10];

  // ---------------- reference model (random phase) ----------------
  bit        m_ex_valid, m_ex_we, m_ex_ld, m_have_md;
  int        m_ex_rd, m_md_cyc, m_cyc, m_cnt;

  task automatic run_random(input int n);
    bit v, u1, u2, we, ld, md, fl, m_busy, m_lu, e_stall, m_issue;
    int rs1, rs2, rd, age;
    logic [1:0] exp_v;
    m_ex_valid = 0; m_ex_we = 0; m_ex_ld = 0; m_ex_rd = 0;
    m_have_md = 0; m_md_cyc = 0; m_cyc = 0; m_cnt = 0;
    for (int i = 0; i < n; i++) begin
      v   = ($urandom_range(0, 9) < 8);
      rs1 = $urandom_range(0, 3); rs2 = $urandom_range(0, 3); rd = $urandom_range(0, 3);
      u1  = $urandom_range(0, 1); u2 = $urandom_range(0, 1); we = ($urandom_range(0, 3) != 0);
      ld  = ($urandom_range(0, 9) < 4); md = ($urandom_range(0, 9) < 1);
      fl  = ($urandom_range(0, 9) < 1);
      drive(v, 5'(rs1), 5'(rs2), u1, u2, 5'(rd), we, ld, md, fl);
      #1;
      age     = m_cyc - m_md_cyc;
      m_busy  = m_have_md && (age >= 1) && (age <= LAT - 1);
      m_lu    = m_ex_valid && m_ex_ld && m_ex_we && (m_ex_rd != 0) &&
                ((u1 && rs1 == m_ex_rd) || (u2 && rs2 == m_ex_rd));
      e_stall = v && !fl && (m_lu || m_busy);
      exp_q.push_back({fl, e_stall});
      exp_v = exp_q.pop_front();
      check("rnd_flush_stall", {30'd0, flush_decode, stall_decode}, {30'd0, exp_v});
      check("rnd_stall_cnt", stall_cnt, m_cnt);
      check("rnd_busy", dbg_busy, m_busy);
      m_issue = v && !e_stall && !fl;
      if (e_stall && m_cnt < 16'hFFFF) m_cnt++;
      if (fl) begin
        m_have_md  = 0;
        m_ex_valid = 0;
      end else if (m_issue) begin
        m_ex_valid = 1; m_ex_rd = rd; m_ex_we = we; m_ex_ld = ld;
        if (md) begin m_have_md = 1; m_md_cyc = m_cyc; end
      end else begin
        m_ex_valid = 0;
      end
      m_cyc++;
      step();
    end
  endtask

  // ---------------- main ----------------
  initial begin
    s_reset_n = 1'b0; s_id_valid = 1'b0; s_id_is_muldiv = 1'b0;
    reset_n = 1'b0;
    idle_in();
    fork
      begin : main_thread
        //               a_rd  we ld  b_rs1 b_rs2 u1 u2 stall
        vecs[0] = '{5'd5,  1, 1, 5'd5,  5'd0, 1, 0, 1};  // lw x5; add rs1=x5
        vecs[1] = '{5'd0,  1, 1, 5'd0,  5'd0, 1, 0, 0};  // lw x0; add rs1=x0
        vecs[2] = '{5'd5,  1, 1, 5'd5,  5'd0, 0, 0, 0};  // lw x5; lui
        vecs[3] = '{5'd5,  1, 1, 5'd1,  5'd5, 1, 1, 1};  // rs2 match
        vecs[4] = '{5'd5,  1, 1, 5'd3,  5'd5, 1, 0, 0};  // rs2 match but unused
        vecs[5] = '{5'd5,  1, 0, 5'd5,  5'd5, 1, 1, 0};  // producer not a load
        vecs[6] = '{5'd5,  0, 1, 5'd5,  5'd5, 1, 1, 0};  // load without write
        vecs[7] = '{5'd31, 1, 1, 5'd31, 5'd31,1, 1, 1};  // both sources hit
        vecs[8] = '{5'd7,  1, 1, 5'd6,  5'd8, 1, 1, 0};  // neighbours only
        vecs[9] = '{5'd0,  1, 1, 5'd0,  5'd0, 1, 1, 0};  // x0 on both sources

        do_reset();
        check("reset_stall_cnt", stall_cnt, 16'd0);
        check("reset_stall", stall_decode, 1'b0);
        check("reset_busy", dbg_busy, 1'b0);
        check("reset_ex_valid", dbg_ex_valid, 1'b0);

        for (int i = 0; i < 10; i++) begin
          drive(1, 5'd0, 5'd0, 0, 0, vecs[i].a_rd, vecs[i].a_we, vecs[i].a_ld, 0, 0);
          #1 check($sformatf("tbl%0d_a_issue", i), stall_decode, 1'b0);
          step();
          drive(1, vecs[i].b_rs1, vecs[i].b_rs2, vecs[i].b_u1, vecs[i].b_u2,
                5'd0, 0, 0, 0, 0);
          #1 check($sformatf("tbl%0d_stall", i), stall_decode, vecs[i].exp_stall);
          if (vecs[i].exp_stall) begin
            exp_cnt++;
            step();
            check($sformatf("tbl%0d_one_cycle", i), stall_decode, 1'b0);
          end
          step();
          check($sformatf("tbl%0d_b_issued", i), dbg_ex_valid, 1'b1);
        end
        check("tbl_stall_cnt", stall_cnt, exp_cnt);

        // mul at N, back-to-back mul waits N+1..N+3, issues at N+4, then id idle
        do_reset();
        drive(1, 5'd0, 5'd0, 0, 0, 5'd9, 1, 0, 1, 0);
        #1 check("md_issue", stall_decode, 1'b0);
        step();
        drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 1, 0);
        for (int k = 1; k <= LAT - 1; k++) begin
          #1 check($sformatf("md_stall_n%0d", k), stall_decode, 1'b1);
          check($sformatf("md_cnt_n%0d", k), dbg_cnt, LAT - k);
          step();
        end
        #1 check("md_issue_n4", stall_decode, 1'b0);
        check("md_stall_cnt", stall_cnt, 16'd3);
        step();
        idle_in();
        for (int k = 1; k <= LAT - 1; k++) begin
          #1 check($sformatf("md2_noid_stall_%0d", k), stall_decode, 1'b0);
          check($sformatf("md2_cnt_%0d", k), dbg_cnt, LAT - k);
          if (k == 1) check("md2_ex_valid", dbg_ex_valid, 1'b1);
          if (k == 2) check("md2_bubble", dbg_ex_valid, 1'b0);
          step();
        end
        check("md2_idle", dbg_busy, 1'b0);
        check("md2_stall_cnt", stall_cnt, 16'd3);

        // load+muldiv producer: flush while load_use and BUSY both hold
        do_reset();
        drive(1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 1, 1, 0);
        step();
        drive(1, 5'd5, 5'd0, 1, 0, 5'd0, 0, 0, 0, 1);
        #1 check("fl_stall", stall_decode, 1'b0);
        check("fl_flush_decode", flush_decode, 1'b1);
        step();
        idle_in();
        #1 check("fl_busy", dbg_busy, 1'b0);
        check("fl_cnt", dbg_cnt, 4'd0);
        check("fl_ex_valid", dbg_ex_valid, 1'b0);
        check("fl_stall_cnt", stall_cnt, 16'd0);

        // same producer without flush: one count for the overlap, then flush at cnt=2
        drive(1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 1, 1, 0);
        step();
        drive(1, 5'd5, 5'd0, 1, 0, 5'd0, 0, 0, 0, 0);
        #1 check("ov_stall", stall_decode, 1'b1);
        step();
        check("ov_stall_cnt", stall_cnt, 16'd1);
        check("ov_cnt2", dbg_cnt, 4'd2);
        check("ov_busy_stall", stall_decode, 1'b1);
        flush_ex = 1'b1;
        #1 check("ov_fl_stall", stall_decode, 1'b0);
        check("ov_fl_flush_decode", flush_decode, 1'b1);
        step();
        idle_in();
        #1 check("ov_fl_busy", dbg_busy, 1'b0);
        check("ov_fl_cnt", dbg_cnt, 4'd0);
        check("ov_fl_ex_valid", dbg_ex_valid, 1'b0);
        check("ov_fl_stall_cnt", stall_cnt, 16'd1);

        // reset pulse mid-BUSY
        do_reset();
        drive(1, 5'd0, 5'd0, 0, 0, 5'd9, 1, 0, 1, 0);
        step();
        drive(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0);
        #1 check("rst_pre_stall", stall_decode, 1'b1);
        reset_n = 1'b0;
        #1 check("rst_stall", stall_decode, 1'b0);
        check("rst_busy", dbg_busy, 1'b0);
        check("rst_cnt", dbg_cnt, 4'd0);
        check("rst_ex_valid", dbg_ex_valid, 1'b0);
        check("rst_stall_cnt", stall_cnt, 16'd0);
        flush_ex = 1'b1;
        #1 check("rst_flush_decode", flush_decode, 1'b1);
        flush_ex = 1'b0;
        @(posedge clk);
        #3 reset_n = 1'b1;
        #1 check("rst_release_stall", stall_decode, 1'b0);
        step();
        check("rst_after_stall", stall_decode, 1'b0);
        check("rst_after_issue", dbg_ex_valid, 1'b1);

        do_reset();
        run_random(3000);
      end
      begin : sat_thread
        repeat (3) @(posedge clk);
        #3 s_reset_n = 1'b1;
        @(posedge clk);
        #1;
        s_id_valid = 1'b1;
        s_id_is_muldiv = 1'b1;
        repeat (150) @(posedge clk);
        #1 check("sat_partial", s_stall_cnt, 16'd140);
        repeat (70200) @(posedge clk);
        #1 check("sat_reached", s_stall_cnt, 16'hFFFF);
        repeat (30) @(posedge clk);
        #1 check("sat_hold", s_stall_cnt, 16'hFFFF);
      end
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
